map_addr_latch_mc: RTL

//  Parametrised address-latch multicart mapper; successor to the fixed 3-bit PRG/CHR discrete latch mapper.
//  A CPU write to $8000-$FFFF latches the bank, mode and mirroring fields from the address bus.

---
 rtl/map_addr_latch_mc.sv | 109 ++++++++++
 1 files changed

// File: rtl/map_addr_latch_mc.sv
// Address-latch multicart mapper: a $8000-$FFFF write latches bank/mode/mirror/lock from the address bus.
// Registers load on negedge m2; mapping and save-state reads are combinational; no backpressure.
module map_addr_latch_mc #(
   parameter int         PRG_W    = 3,
   parameter int         CHR_W    = 3,
   parameter bit         RMW_FILT = 1'b1,
   parameter bit         LOCK_EN  = 1'b1,
   parameter logic [7:0] MAP_IDX  = 8'd58
) (
   input  logic                m2,
   input  logic                map_rst,
   input  logic [15:0]         cpu_addr,
   input  logic [7:0]          cpu_dat,
   input  logic                cpu_rw,
   input  logic                cpu_ce,
   input  logic [13:0]         ppu_addr,
   input  logic                ppu_we,
   input  logic                cfg_chr_ram,
   input  logic                ss_act,
   input  logic                ss_we,
   input  logic [7:0]          ss_addr,
   output logic [7:0]          ss_rdat,
   output logic [14+PRG_W-1:0] prg_addr,
   output logic [13+CHR_W-1:0] chr_addr,
   output logic                ciram_a10,
   output logic                ciram_ce,
   output logic                chr_we
);

   localparam int MODE_B = PRG_W + CHR_W;
   localparam int MIR_B  = MODE_B + 1;
   localparam int LOCK_B = MODE_B + 2;

   logic [PRG_W-1:0] prg;
   logic [CHR_W-1:0] chr;
   logic             mode;
   logic             mir;
   logic             lock;
   logic             wr_prev;

   logic             rom_wr;
   logic             filt;
   logic [PRG_W-1:0] prg_sel;
   logic             unused_bits;

   assign rom_wr      = !cpu_ce && !cpu_rw;
   assign filt        = RMW_FILT && wr_prev;
   assign unused_bits = cpu_addr[15];

   always_ff @(negedge m2) begin
      if (ss_act) begin
         // Save-state restore bypasses reset, lock and the RMW filter.
         if (ss_we) begin
            case (ss_addr)
               8'd0: prg <= PRG_W'(cpu_dat);
               8'd1: chr <= CHR_W'(cpu_dat);
               8'd2: begin
                  mode <= cpu_dat[0];
                  mir  <= cpu_dat[1];
                  lock <= LOCK_EN && cpu_dat[2];
               end
               8'd3: wr_prev <= cpu_dat[0];
               default: ;
            endcase
         end
      end else if (map_rst) begin
         prg     <= '0;
         chr     <= '0;
         mode    <= 1'b0;
         mir     <= 1'b0;
         lock    <= 1'b0;
         wr_prev <= 1'b0;
      end else begin
         // Filtered writes still count as the previous write, so a run of ROM writes only takes the first.
         wr_prev <= rom_wr;
         if (rom_wr && !lock && !filt) begin
            prg  <= cpu_addr[PRG_W-1:0];
            chr  <= cpu_addr[MODE_B-1:PRG_W];
            mode <= cpu_addr[MODE_B];
            mir  <= cpu_addr[MIR_B];
            lock <= LOCK_EN && cpu_addr[LOCK_B];
         end
      end
   end

   always_comb begin
      ss_rdat = 8'hFF;
      case (ss_addr)
         8'd0:   ss_rdat = 8'(prg);
         8'd1:   ss_rdat = 8'(chr);
         8'd2:   ss_rdat = {5'd0, lock, mir, mode};
         8'd3:   ss_rdat = {7'd0, wr_prev};
         8'd127: ss_rdat = MAP_IDX;
         default: ss_rdat = 8'hFF;
      endcase
   end

   // 32KB mode replaces the bank LSB with A14.
   always_comb begin
      prg_sel = mode ? prg : ((prg & ~PRG_W'(1)) | PRG_W'(cpu_addr[14]));
   end

   assign prg_addr  = {prg_sel, cpu_addr[13:0]};
   assign chr_addr  = {chr, ppu_addr[12:0]};
   assign ciram_a10 = mir ? ppu_addr[11] : ppu_addr[10];
   assign ciram_ce  = !ppu_addr[13];
   assign chr_we    = cfg_chr_ram && !ppu_we && !ppu_addr[13];

endmodule
